// File: rtl/vga_pkg.sv
// Shared types and constants for the VGA framebuffer arbiter.
// FSM state codes, requester owner tags and default framebuffer depth.
package vga_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SCAN  = 2'd1,
    ST_HOST  = 2'd2,
    ST_FLUSH = 2'd3
  } state_t;

  localparam logic OWN_SCAN = 1'b0;
  localparam logic OWN_HOST = 1'b1;

  localparam int FB_DEPTH_DEF = 480000;

  typedef struct packed {
    logic vld;
    logic own;
    logic zero;
  } rd_tag_t;

endpackage

// File: rtl/vga_fb_arbiter_if.sv
// Scan-out, host and SRAM bus bundle for the framebuffer arbiter.
// master = arbiter side, slave = requesters plus SRAM.
interface vga_fb_arbiter_if #(
  parameter int ADDR_W = 19,
  parameter int DATA_W = 8
);
  logic              scan_req;
  logic [ADDR_W-1:0] scan_addr;
  logic [DATA_W-1:0] scan_data;
  logic              scan_valid;
  logic              host_req;
  logic              host_we;
  logic [ADDR_W-1:0] host_addr;
  logic [DATA_W-1:0] host_wdata;
  logic              host_ready;
  logic [DATA_W-1:0] host_rdata;
  logic              host_rvalid;
  logic              mem_en;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;

  modport master (
    input  scan_req, scan_addr,
    output scan_data, scan_valid,
    input  host_req, host_we,
    input  host_addr, host_wdata,
    output host_ready, host_rdata,
    output host_rvalid,
    output mem_en, mem_we,
    output mem_addr, mem_wdata,
    input  mem_rdata
  );

  modport slave (
    output scan_req, scan_addr,
    input  scan_data, scan_valid,
    output host_req, host_we,
    output host_addr, host_wdata,
    input  host_ready, host_rdata,
    input  host_rvalid,
    input  mem_en, mem_we,
    input  mem_addr, mem_wdata,
    output mem_rdata
  );
endinterface

// File: rtl/vga_arb_rd_pipe.sv
// Two-stage read tag pipeline: tracks {valid, owner} of each
// issued read and steers the SRAM data to scan or host, in order.
module vga_arb_rd_pipe
  import vga_pkg::*;
#(
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_vld,
  input  logic              i_own,
  input  logic              i_zero,
  input  logic [DATA_W-1:0] i_rdata,
  output logic              o_scan_valid,
  output logic [DATA_W-1:0] o_scan_data,
  output logic              o_host_rvalid,
  output logic [DATA_W-1:0] o_host_rdata
);

  rd_tag_t           r_tag1;
  rd_tag_t           r_tag2;
  logic              r_scan_valid;
  logic [DATA_W-1:0] r_scan_data;
  logic              r_host_rvalid;
  logic [DATA_W-1:0] r_host_rdata;

  logic              w_sel_scan;
  logic              w_sel_host;
  logic [DATA_W-1:0] w_data;

  assign w_sel_scan = r_tag2.vld &
                      (r_tag2.own == OWN_SCAN);
  assign w_sel_host = r_tag2.vld &
                      (r_tag2.own == OWN_HOST);
  assign w_data = r_tag2.zero ? '0 : i_rdata;

  // Tag shift: stage1 aligns with mem_en, stage2 with mem_rdata.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_tag1 <= '0;
      r_tag2 <= '0;
    end else begin
      r_tag1 <= '{vld: i_vld, own: i_own, zero: i_zero};
      r_tag2 <= r_tag1;
    end
  end

  // Registered read-data outputs, one pulse per issued read.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_scan_valid  <= 1'b0;
      r_scan_data   <= '0;
      r_host_rvalid <= 1'b0;
      r_host_rdata  <= '0;
    end else begin
      r_scan_valid  <= w_sel_scan;
      r_scan_data   <= w_sel_scan ? w_data : '0;
      r_host_rvalid <= w_sel_host;
      r_host_rdata  <= w_sel_host ? w_data : '0;
    end
  end

  assign o_scan_valid  = r_scan_valid;
  assign o_scan_data   = r_scan_data;
  assign o_host_rvalid = r_host_rvalid;
  assign o_host_rdata  = r_host_rdata;

endmodule

// File: rtl/vga_fb_arbiter.sv
// Single-port framebuffer SRAM arbiter, scan-out has fixed priority.
// Optional host stall counter port enabled by VGA_ARB_STATS_EN.
module vga_fb_arbiter
  import vga_pkg::*;
#(
  parameter int ADDR_W   = 19,
  parameter int DATA_W   = 8,
  parameter int FB_DEPTH = FB_DEPTH_DEF
) (
  input  logic        pixel_clk,
  input  logic        reset,
  input  logic        frame_start,
`ifdef VGA_ARB_STATS_EN
  output logic [15:0] host_stall_cnt,
`endif
  vga_fb_arbiter_if.master bus
);

  localparam logic [ADDR_W-1:0] LP_DEPTH =
    ADDR_W'(FB_DEPTH);

  state_t            r_state;
  logic              r_flush_cnt;
  logic              r_mem_en;
  logic              r_mem_we;
  logic [ADDR_W-1:0] r_mem_addr;
  logic [DATA_W-1:0] r_mem_wdata;

  logic w_flush;
  logic w_scan_fire;
  logic w_host_fire;
  logic w_scan_in;
  logic w_host_in;
  logic w_iss_vld;
  logic w_iss_own;
  logic w_iss_zero;

  assign w_flush     = (r_state == ST_FLUSH);
  assign w_scan_fire = reset & bus.scan_req;
  assign w_host_fire = reset & bus.host_req &
                       ~bus.scan_req & ~w_flush;
  assign w_scan_in   = (bus.scan_addr < LP_DEPTH);
  assign w_host_in   = (bus.host_addr < LP_DEPTH);

  assign bus.host_ready = w_host_fire;

  assign w_iss_vld  = w_scan_fire |
                      (w_host_fire & ~bus.host_we);
  assign w_iss_own  = w_scan_fire ? OWN_SCAN : OWN_HOST;
  assign w_iss_zero = w_scan_fire ? ~w_scan_in
                                  : ~w_host_in;

  // Arbitration FSM; frame_start holds off the host two cycles.
  always_ff @(posedge pixel_clk or negedge reset) begin
    if (!reset) begin
      r_state     <= ST_IDLE;
      r_flush_cnt <= 1'b0;
    end else if (frame_start) begin
      r_state     <= ST_FLUSH;
      r_flush_cnt <= 1'b0;
    end else if (r_state == ST_FLUSH) begin
      if (r_flush_cnt) begin
        r_state     <= ST_IDLE;
        r_flush_cnt <= 1'b0;
      end else begin
        r_flush_cnt <= 1'b1;
      end
    end else begin
      unique case (1'b1)
        w_scan_fire: r_state <= ST_SCAN;
        w_host_fire: r_state <= ST_HOST;
        default:     r_state <= ST_IDLE;
      endcase
    end
  end

  // Registered SRAM command; out-of-range accesses stay off the bus.
  always_ff @(posedge pixel_clk or negedge reset) begin
    if (!reset) begin
      r_mem_en    <= 1'b0;
      r_mem_we    <= 1'b0;
      r_mem_addr  <= '0;
      r_mem_wdata <= '0;
    end else begin
      unique case (1'b1)
        w_scan_fire: begin
          r_mem_en    <= w_scan_in;
          r_mem_we    <= 1'b0;
          r_mem_addr  <= bus.scan_addr;
          r_mem_wdata <= '0;
        end
        w_host_fire: begin
          r_mem_en    <= w_host_in;
          r_mem_we    <= bus.host_we & w_host_in;
          r_mem_addr  <= bus.host_addr;
          r_mem_wdata <= bus.host_wdata;
        end
        default: begin
          r_mem_en <= 1'b0;
          r_mem_we <= 1'b0;
        end
      endcase
    end
  end

  assign bus.mem_en    = r_mem_en;
  assign bus.mem_we    = r_mem_we;
  assign bus.mem_addr  = r_mem_addr;
  assign bus.mem_wdata = r_mem_wdata;

  vga_arb_rd_pipe #(
    .DATA_W(DATA_W)
  ) u_rd_pipe (
    .clk          (pixel_clk),
    .rst_n        (reset),
    .i_vld        (w_iss_vld),
    .i_own        (w_iss_own),
    .i_zero       (w_iss_zero),
    .i_rdata      (bus.mem_rdata),
    .o_scan_valid (bus.scan_valid),
    .o_scan_data  (bus.scan_data),
    .o_host_rvalid(bus.host_rvalid),
    .o_host_rdata (bus.host_rdata)
  );

`ifdef VGA_ARB_STATS_EN
  logic [15:0] r_stall_cnt;

  // Saturating count of host cycles spent waiting.
  always_ff @(posedge pixel_clk or negedge reset) begin
    if (!reset) begin
      r_stall_cnt <= '0;
    end else if (frame_start) begin
      r_stall_cnt <= '0;
    end else if (bus.host_req & ~w_host_fire &
                 (r_stall_cnt != 16'hFFFF)) begin
      r_stall_cnt <= r_stall_cnt + 16'd1;
    end
  end

  assign host_stall_cnt = r_stall_cnt;
`endif

endmodule
